// File: rtl/cru_pkg.sv
// Shared constants for the CRU-mapped flag register / interrupt controller.
package cru_pkg;

  localparam logic [3:0]  BST_INTA = 4'b0101;
  localparam int unsigned FLAG_OFS = 0;
  localparam int unsigned MASK_OFS = 16;
  localparam int unsigned PEND_OFS = 24;
  localparam int unsigned WIN_BITS = 32;
  localparam int unsigned MAX_NCH  = 8;

endpackage

// File: rtl/irq_channel.sv
// One interrupt channel: rising-edge latch into pending, CRU-writable mask.
// A new edge always beats a clear in the same cycle so no request is lost.
module irq_channel #(
  parameter logic MASK_RST = 1'b1
) (
  input  logic clk_25mhz,
  input  logic reset,
  input  logic irq_in,
  input  logic mask_we,
  input  logic mask_wd,
  input  logic pend_clr,
  output logic pending,
  output logic mask
);

  logic irq_d;
  logic rise;

  assign rise = irq_in & ~irq_d;

  // irq_d tracks the input even in reset so a level held across release is not an edge
  always_ff @(posedge clk_25mhz) begin
    irq_d <= irq_in;
    if (reset) begin
      pending <= 1'b0;
      mask    <= MASK_RST;
    end else begin
      if (rise)          pending <= 1'b1;
      else if (pend_clr) pending <= 1'b0;
      if (mask_we)       mask    <= mask_wd;
    end
  end

endmodule

// File: rtl/cru_intc.sv
// CRU flag register plus NCH-channel edge-latched, priority-encoded interrupt controller.
// Define CRU_INTC_PASSTHRU_EN to OR the raw masked irq_in into int_o/int_lvl (zero latency).
module cru_intc
  import cru_pkg::*;
#(
  parameter int unsigned     NCH      = 4,
  parameter logic [15:0]     BASE     = 16'h1EC0,
  parameter int unsigned     LVL_BASE = 4,
  parameter logic [NCH-1:0]  MASK_RST = {NCH{1'b1}}
) (
  input  logic           clk_25mhz,
  input  logic           reset,
  input  logic [15:0]    cab,
  input  logic           cruout,
  input  logic           cruclk,
  input  logic [3:0]     bst,
  input  logic [NCH-1:0] irq_in,
  output logic           cru_sel,
  output logic           cruin_o,
  output logic           int_o,
  output logic [3:0]     int_lvl,
  output logic [15:0]    flag_o
);

  localparam int unsigned IDX_W = $clog2(WIN_BITS);

  logic             cruclk_d;
  logic             wr;
  logic [IDX_W-1:0] idx;
  logic [15:0]      flag;
  logic [NCH-1:0]   mask;
  logic [NCH-1:0]   pend;
  logic [NCH-1:0]   mask_we;
  logic [NCH-1:0]   pend_clr;
  logic [NCH-1:0]   act;
  logic [NCH-1:0]   req;
  logic             cab_unused;

  assign cab_unused = cab[0];
  assign cru_sel    = (cab[15:6] == BASE[15:6]);
  assign idx        = cab[5:1];
  assign wr         = cru_sel & cruclk_d & ~cruclk;
  assign flag_o     = flag;

  // cruclk falling-edge detect and flag register writes
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      cruclk_d <= 1'b0;
      flag     <= '0;
    end else begin
      cruclk_d <= cruclk;
      if (wr && idx < IDX_W'(MASK_OFS)) flag[idx[3:0]] <= cruout;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign mask_we[k]  = wr && (idx == IDX_W'(MASK_OFS + k));
    assign pend_clr[k] = (wr && cruout && (idx == IDX_W'(PEND_OFS + k)))
                       || ((bst == BST_INTA) && (cab[5:2] == 4'(LVL_BASE + k)));

    irq_channel #(.MASK_RST(MASK_RST[k])) u_ch (
      .clk_25mhz (clk_25mhz),
      .reset     (reset),
      .irq_in    (irq_in[k]),
      .mask_we   (mask_we[k]),
      .mask_wd   (cruout),
      .pend_clr  (pend_clr[k]),
      .pending   (pend[k]),
      .mask      (mask[k])
    );
  end

  // CRU read mux; unmapped bits and out-of-window addresses read as 1
  always_comb begin
    cruin_o = 1'b1;
    if (cru_sel) begin
      if (idx < IDX_W'(MASK_OFS)) cruin_o = flag[idx[3:0]];
      for (int k = 0; k < NCH; k++) begin
        if (idx == IDX_W'(MASK_OFS + k)) cruin_o = mask[k];
        if (idx == IDX_W'(PEND_OFS + k)) cruin_o = pend[k];
      end
    end
  end

  assign act = pend & mask;
`ifdef CRU_INTC_PASSTHRU_EN
  assign req = act | (irq_in & mask);
`else
  assign req = act;
`endif
  assign int_o = |req;

  // lowest channel wins: scan downward so the last hit is the lowest k
  always_comb begin
    int_lvl = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req[k]) int_lvl = 4'(LVL_BASE + 32'(k));
    end
  end

endmodule
